// File: rtl/regfile_wb_queue.sv
// Write-back arbiter for the integer register file write port.
// Single-cycle ALU results go straight to the output register. Long-latency
// results are buffered in a DEPTH-entry FIFO. A starvation counter limits how
// long the ALU may keep the FIFO head waiting. Pending flags let the issue
// stage detect RAW hazards against writes that are queued or in flight.
module regfile_wb_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_we,
  input  logic [4:0]                   alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  output logic                         alu_stall,
  input  logic                         ll_valid,
  output logic                         ll_ready,
  input  logic [4:0]                   ll_rd,
  input  logic [XLEN-1:0]              ll_data,
  output logic                         regwrite,
  output logic [4:0]                   writereg,
  output logic [XLEN-1:0]              writedata,
  input  logic [4:0]                   rs1_q,
  input  logic [4:0]                   rs2_q,
  output logic                         rs1_pending,
  output logic                         rs2_pending,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX+1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve;

  logic fifo_empty;
  logic push;
  logic pop;
  logic override;
  logic alu_ok;
  logic rs1_hit;
  logic rs2_hit;

  // Handshake and arbitration decisions, all from registered state.
  always_comb begin
    fifo_empty = (count == '0);
    ll_ready   = (count != FULL_CNT);
    push       = ll_valid && ll_ready && (ll_rd != 5'd0);
    override   = (starve == STARVE_LIM) && !fifo_empty;
    alu_ok     = alu_we && (alu_rd != 5'd0);
    pop        = override || (!alu_ok && !fifo_empty);
    alu_stall  = override && alu_we;
    fifo_count = count;
  end

  // Scan the live FIFO window for destinations matching the queries.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (rd_mem[head + AW'(i)] == rs1_q) rs1_hit = 1'b1;
        if (rd_mem[head + AW'(i)] == rs2_q) rs2_hit = 1'b1;
      end
    end
    rs1_pending = (rs1_q != 5'd0) && (rs1_hit || (regwrite && (writereg == rs1_q)));
    rs2_pending = (rs2_q != 5'd0) && (rs2_hit || (regwrite && (writereg == rs2_q)));
  end

  // FIFO storage; contents are only meaningful inside the head/count window.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= ll_rd;
      data_mem[tail] <= ll_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Output register and starvation counter, in arbitration priority order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite  <= 1'b0;
      writereg  <= '0;
      writedata <= '0;
      starve    <= '0;
    end else if (override) begin
      regwrite  <= 1'b1;
      writereg  <= rd_mem[head];
      writedata <= data_mem[head];
      starve    <= '0;
    end else if (alu_ok) begin
      regwrite  <= 1'b1;
      writereg  <= alu_rd;
      writedata <= alu_data;
      starve    <= fifo_empty ? '0 : starve + SW'(1);
    end else if (!fifo_empty) begin
      regwrite  <= 1'b1;
      writereg  <= rd_mem[head];
      writedata <= data_mem[head];
      starve    <= '0;
    end else begin
      regwrite  <= 1'b0;
      starve    <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: ALU path, FIFO path, starvation
// override, x0 discard, pending flags, full-FIFO backpressure and async reset.
module tb_regfile_wb_queue;

  logic        clk;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        regwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic        rs1_pending;
  logic        rs2_pending;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  regfile_wb_queue #(
    .DEPTH(4),
    .XLEN(32),
    .STARVE_MAX(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alu_we(alu_we),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .alu_stall(alu_stall),
    .ll_valid(ll_valid),
    .ll_ready(ll_ready),
    .ll_rd(ll_rd),
    .ll_data(ll_data),
    .regwrite(regwrite),
    .writereg(writereg),
    .writedata(writedata),
    .rs1_q(rs1_q),
    .rs2_q(rs2_q),
    .rs1_pending(rs1_pending),
    .rs2_pending(rs2_pending),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; alu_we = 1'b0; alu_rd = '0; alu_data = '0;
    ll_valid = 1'b0; ll_rd = '0; ll_data = '0; rs1_q = 5'd5; rs2_q = 5'd0;

    // Reset state
    #2;
    chk("rst_regwrite", regwrite, 0);
    chk("rst_writereg", writereg, 0);
    chk("rst_writedata", writedata, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ll_ready", ll_ready, 1);
    chk("rst_alu_stall", alu_stall, 0);
    chk("rst_pending", rs1_pending, 0);
    step();
    rst = 1'b1;

    // Single ALU write: visible one cycle later, gone the cycle after
    alu_we = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_we = 1'b0;
    chk("alu_regwrite", regwrite, 1);
    chk("alu_writereg", writereg, 5);
    chk("alu_writedata", writedata, 32'hDEADBEEF);
    #1 chk("alu_pending_out", rs1_pending, 1);
    step();
    chk("alu_regwrite_off", regwrite, 0);

    // Fill FIFO under continuous ALU writes, then starvation override
    alu_we = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    ll_valid = 1'b1; ll_rd = 5'd1; ll_data = 32'h11;
    #1 chk("fill_ready0", ll_ready, 1);
    step();
    chk("fill_wr9", writereg, 9);
    chk("fill_cnt1", fifo_count, 1);
    ll_rd = 5'd2; ll_data = 32'h22;
    step();
    chk("fill_cnt2", fifo_count, 2);
    ll_rd = 5'd3; ll_data = 32'h33;
    step();
    chk("fill_cnt3", fifo_count, 3);
    ll_rd = 5'd4; ll_data = 32'h44;
    #1 chk("fill_nostall", alu_stall, 0);
    step();
    ll_valid = 1'b0;
    chk("fill_cnt4", fifo_count, 4);
    chk("fill_ready_full", ll_ready, 0);
    chk("starve_stall", alu_stall, 1);
    step();
    chk("starve_wr1", writereg, 1);
    chk("starve_data11", writedata, 32'h11);
    chk("starve_cnt3", fifo_count, 3);
    chk("starve_stall_off", alu_stall, 0);
    step();
    alu_we = 1'b0;
    chk("held_alu_wr9", writereg, 9);
    chk("held_alu_data", writedata, 32'h99);
    chk("held_alu_cnt3", fifo_count, 3);
    step();
    chk("drain_wr2", writereg, 2);
    chk("drain_data22", writedata, 32'h22);
    step();
    chk("drain_wr3", writereg, 3);
    step();
    chk("drain_wr4", writereg, 4);
    chk("drain_cnt0", fifo_count, 0);
    step();
    chk("drain_idle", regwrite, 0);

    // x0 writes are discarded
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h55;
    #1 chk("x0_ll_ready", ll_ready, 1);
    step();
    ll_valid = 1'b0;
    chk("x0_ll_cnt", fifo_count, 0);
    chk("x0_ll_nowr", regwrite, 0);
    alu_we = 1'b1; alu_rd = 5'd0; alu_data = 32'h66;
    step();
    alu_we = 1'b0;
    chk("x0_alu_nowr", regwrite, 0);

    // Pending flags for a queued long-latency result
    rs1_q = 5'd7; rs2_q = 5'd8;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h77;
    #1 chk("pend_not_yet", rs1_pending, 0);
    step();
    ll_valid = 1'b0;
    chk("pend_q_rs1", rs1_pending, 1);
    chk("pend_q_rs2", rs2_pending, 0);
    step();
    chk("pend_wr7", writereg, 7);
    chk("pend_regwrite", regwrite, 1);
    chk("pend_hold", rs1_pending, 1);
    step();
    chk("pend_drop", rs1_pending, 0);

    // Full FIFO with simultaneous ll_valid and an override pop
    alu_we = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
    ll_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ll_rd = 5'(13 + i); ll_data = 32'(16'h130 + 16 * i);
      step();
    end
    ll_rd = 5'd12; ll_data = 32'h120;
    #1 chk("full_ready0", ll_ready, 0);
    chk("full_stall", alu_stall, 1);
    step();
    ll_valid = 1'b0; alu_we = 1'b0;
    chk("full_cnt3", fifo_count, 3);
    chk("full_ready1", ll_ready, 1);
    chk("full_wr13", writereg, 13);
    step();
    chk("full_pop14", writereg, 14);
    chk("full_cnt2", fifo_count, 2);

    // Three queued entries plus a live write, then async reset
    alu_we = 1'b1; alu_rd = 5'd11; alu_data = 32'hB0;
    ll_valid = 1'b1; ll_rd = 5'd17; ll_data = 32'h170;
    step();
    ll_valid = 1'b0; rs1_q = 5'd17;
    chk("pre_rst_wr11", writereg, 11);
    chk("pre_rst_cnt3", fifo_count, 3);
    #1 chk("pre_rst_pend_tail", rs1_pending, 1);
    rst = 1'b0;
    #1;
    chk("arst_regwrite", regwrite, 0);
    chk("arst_writereg", writereg, 0);
    chk("arst_writedata", writedata, 0);
    chk("arst_cnt", fifo_count, 0);
    chk("arst_ready", ll_ready, 1);
    chk("arst_pending", rs1_pending, 0);
    chk("arst_stall", alu_stall, 0);
    alu_we = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    chk("post_rst_nowr", regwrite, 0);
    chk("post_rst_cnt", fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back arbiter and buffer that owns the single write port of the integer register file. It merges single-cycle ALU results with results from long-latency units (loads, mul/div), which pass through a DEPTH-entry FIFO. It drives regwrite/writereg/writedata from registered outputs and reports per-register pending status so the issue stage can stall on RAW hazards against queued results.

## Interface
- DEPTH, 4, long-latency FIFO entries; power of two, >= 2
- XLEN, 32, data width
- STARVE_MAX, 3, max consecutive cycles the ALU may pre-empt a non-empty FIFO
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- alu_we  in  1  ALU result valid
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_stall  out  1  ALU write not accepted this cycle; upstream holds alu_we/alu_rd/alu_data
- ll_valid  in  1  long-latency result valid
- ll_ready  out  1  FIFO can accept; transfer when ll_valid && ll_ready
- ll_rd  in  5  long-latency destination register
- ll_data  in  XLEN  long-latency result
- regwrite  out  1  register file write enable (registered)
- writereg  out  5  register file write address (registered)
- writedata  out  XLEN  register file write data (registered)
- rs1_q, rs2_q  in  5  query register indices
- rs1_pending, rs2_pending  out  1  query register has an outstanding write
- fifo_count  out  clog2(DEPTH+1)  valid FIFO entries

## Operation
- Writes to x0 are discarded at entry: an ALU write with alu_rd == 0 is consumed without effect. An ll transfer with ll_rd == 0 completes its handshake but is not enqueued.
- FIFO: circular buffer with head and tail pointers plus count. ll_ready = (count != DEPTH), evaluated from registered count. A pop in the same cycle does not free a slot for a push while full.
- Output selection each cycle, in priority order:
  - If starve == STARVE_MAX and FIFO is non-empty: pop the FIFO head into the output register. alu_stall = alu_we. starve <= 0.
  - Else if alu_we && alu_rd != 0: load the ALU result into the output register. alu_stall = 0. If the FIFO is non-empty, starve <= starve + 1.
  - Else if FIFO is non-empty: pop the head. starve <= 0.
  - Else: regwrite <= 0.
- starve <= 0 whenever the FIFO is empty.
- alu_stall is combinational and is asserted only in the starvation-override case.
- rsX_pending = (rsX_q != 0) && (any valid FIFO entry has rd == rsX_q, or (regwrite && writereg == rsX_q)). It is combinational from state. An entry pushed this cycle counts from the next cycle.
- Program ordering between the ALU and long-latency writes to the same rd is the issuer's responsibility; it uses the pending flags for this. This block does not reorder.
- fifo_count: push and pop in the same cycle leave the count unchanged.

## Timing
- Reset (asynchronous, rst low) clears the following immediately:
  - regwrite = 0, writereg = 0, writedata = 0
  - count = 0, head = 0, tail = 0, starve = 0
  - ll_ready = 1, pending = 0, alu_stall = 0
- A reset mid-operation drops all queued entries.
- ALU latency: alu_we at cycle N -> regwrite = 1 in cycle N+1.
- Long-latency latency: accepted at cycle N, with an empty FIFO and no ALU write at N+1 -> popped at N+1 -> regwrite = 1 in cycle N+2.
- Throughput: one register file write per cycle maximum. The FIFO sustains one push and one pop per cycle.
- Worst-case FIFO head wait under continuous ALU writes: STARVE_MAX + 1 cycles.

## Test plan
- Reset, then alu_we = 1, alu_rd = 5, alu_data = 0xDEADBEEF at cycle 0 -> regwrite = 1, writereg = 5, writedata = 0xDEADBEEF in cycle 1; regwrite = 0 in cycle 2.
- Push 4 ll entries (rd 1..4, data 0x11..0x44) while alu_we is held high with rd = 9:
  - ll_ready = 0 after the fourth push; fifo_count = 4.
  - After 3 ALU writes, alu_stall = 1 for one cycle and writereg = 1, data 0x11 appears.
  - The held ALU write then completes.
- ll push with ll_rd = 0 -> handshake completes, fifo_count stays 0, no regwrite. alu_we with alu_rd = 0 -> no regwrite.
- Enqueue rd = 7, query rs1_q = 7, rs2_q = 8:
  - rs1_pending = 1, rs2_pending = 0.
  - Pending stays 1 through the cycle where writereg = 7 and regwrite = 1, and drops the cycle after.
- FIFO full with a simultaneous ll_valid and pop -> no push is accepted; count goes 4 -> 3; ll_ready = 1 the next cycle.
- Assert rst low with 3 entries queued and regwrite = 1 -> all outputs zero immediately, fifo_count = 0, no writes after rst is released.
